// File: rtl/scroll_bg_mapper_if.sv
// Pixel/ROM/palette bundle for scroll_bg_mapper.
// Optional VSCROLL_EN adds vspeed and y_off.
interface scroll_bg_mapper_if #(
  parameter int ADDR_W = 18,
  parameter int IDX_W  = 5
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic [1:0]        mode;
  logic [3:0]        speed;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q;
  logic [11:0]       pal_rgb;
  logic [3:0]        red;
  logic [3:0]        green;
  logic [3:0]        blue;
  logic              transparent;
  logic [8:0]        x_off;
`ifdef VSCROLL_EN
  logic [3:0]        vspeed;
  logic [7:0]        y_off;

  modport master (
    output DrawX, DrawY, blank, mode, speed,
    output rom_q, pal_rgb, vspeed,
    input  rom_addr, red, green, blue,
    input  transparent, x_off, y_off
  );

  modport slave (
    input  DrawX, DrawY, blank, mode, speed,
    input  rom_q, pal_rgb, vspeed,
    output rom_addr, red, green, blue,
    output transparent, x_off, y_off
  );
`else
  modport master (
    output DrawX, DrawY, blank, mode, speed,
    output rom_q, pal_rgb,
    input  rom_addr, red, green, blue,
    input  transparent, x_off
  );

  modport slave (
    input  DrawX, DrawY, blank, mode, speed,
    input  rom_q, pal_rgb,
    output rom_addr, red, green, blue,
    output transparent, x_off
  );
`endif
endinterface

// File: rtl/scroll_bg_mapper.sv
// Scrolling background mapper: DrawX/DrawY -> ROM -> palette -> RGB.
// Optional vertical scroll is enabled by defining VSCROLL_EN.
module scroll_bg_mapper #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 18,
  parameter int IDX_W       = 5,
  parameter int ROM_LAT     = 1,
  parameter int V_ACTIVE    = 480,
  parameter int KEY_IDX     = 0
) (
  input logic                vga_clk,
  input logic                reset_n,
  scroll_bg_mapper_if.slave  bus
);

  typedef enum logic [1:0] {
    M_HOLD  = 2'b00,
    M_RIGHT = 2'b01,
    M_LEFT  = 2'b10,
    M_HOME  = 2'b11
  } mode_e;

  localparam logic [10:0] W11 = 11'(IMG_W);
  localparam logic [10:0] H11 = 11'(IMG_H);

  mode_e             r_mode;
  mode_e             w_mode_nxt;
  logic [8:0]        r_x_off;
  logic [8:0]        w_x_nxt;
  logic              w_bound;

  logic [10:0]       w_xr_sum;
  logic [8:0]        w_x_right;
  logic [8:0]        w_x_left;

  logic [9:0]        w_sx;
  logic [9:0]        w_sy;
  logic [10:0]       w_ix_sum;
  logic [10:0]       w_ix;
  logic [10:0]       w_row;
  logic              w_oob;
  logic [ADDR_W-1:0] w_lin;
  logic [ADDR_W-1:0] w_addr;

  logic [ADDR_W-1:0] r_rom_addr;
  logic [ROM_LAT:0]  r_bl_sr;
  logic [ROM_LAT:0]  r_oob_sr;
  logic              w_vis;
  logic [11:0]       r_rgb;
  logic              r_trans;

`ifdef VSCROLL_EN
  localparam logic [9:0] H10 = 10'(IMG_H);
  logic [7:0]        r_y_off;
  logic [7:0]        w_y_nxt;
  logic [9:0]        w_yd_sum;
  logic [7:0]        w_y_down;
  logic [7:0]        w_y_up;
  logic [10:0]       w_iy_sum;
`endif

  assign w_bound = (bus.DrawX == 10'd0)
                && (bus.DrawY == 10'(V_ACTIVE));

  assign w_xr_sum  = {2'b0, r_x_off} + {7'b0, bus.speed};
  assign w_x_right = 9'((w_xr_sum >= W11)
                   ? w_xr_sum - W11 : w_xr_sum);
  assign w_x_left  = 9'((r_x_off >= {5'b0, bus.speed})
                   ? {2'b0, r_x_off} - {7'b0, bus.speed}
                   : {2'b0, r_x_off} + W11
                     - {7'b0, bus.speed});

`ifdef VSCROLL_EN
  assign w_yd_sum = {2'b0, r_y_off} + {6'b0, bus.vspeed};
  assign w_y_down = 8'((w_yd_sum >= H10)
                  ? w_yd_sum - H10 : w_yd_sum);
  assign w_y_up   = 8'((r_y_off >= {4'b0, bus.vspeed})
                  ? {2'b0, r_y_off} - {6'b0, bus.vspeed}
                  : {2'b0, r_y_off} + H10
                    - {6'b0, bus.vspeed});
`endif

  // Scroll FSM next state: mode/speed only act on the frame boundary.
  always_comb begin
    w_mode_nxt = r_mode;
    w_x_nxt    = r_x_off;
`ifdef VSCROLL_EN
    w_y_nxt    = r_y_off;
`endif
    if (w_bound) begin
      w_mode_nxt = mode_e'(bus.mode);
      unique case (w_mode_nxt)
        M_HOLD: begin
        end
        M_RIGHT: begin
          w_x_nxt = w_x_right;
`ifdef VSCROLL_EN
          w_y_nxt = w_y_down;
`endif
        end
        M_LEFT: begin
          w_x_nxt = w_x_left;
`ifdef VSCROLL_EN
          w_y_nxt = w_y_up;
`endif
        end
        M_HOME: begin
          w_x_nxt = 9'd0;
`ifdef VSCROLL_EN
          w_y_nxt = 8'd0;
`endif
        end
      endcase
    end
  end

  // Scroll FSM state: latched mode and offsets.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode  <= M_HOLD;
      r_x_off <= 9'd0;
`ifdef VSCROLL_EN
      r_y_off <= 8'd0;
`endif
    end else begin
      r_mode  <= w_mode_nxt;
      r_x_off <= w_x_nxt;
`ifdef VSCROLL_EN
      r_y_off <= w_y_nxt;
`endif
    end
  end

  assign w_sx     = bus.DrawX >> SCALE_SHIFT;
  assign w_sy     = bus.DrawY >> SCALE_SHIFT;
  assign w_ix_sum = {1'b0, w_sx} + {2'b0, r_x_off};
  assign w_ix     = (w_ix_sum >= W11)
                  ? w_ix_sum - W11 : w_ix_sum;

`ifdef VSCROLL_EN
  assign w_iy_sum = {1'b0, w_sy} + {3'b0, r_y_off};
  assign w_row    = (w_iy_sum >= H11)
                  ? w_iy_sum - H11 : w_iy_sum;
`else
  assign w_row    = {1'b0, w_sy};
`endif

  assign w_oob  = ({1'b0, w_sx} >= W11)
               || ({1'b0, w_sy} >= H11);
  assign w_lin  = ADDR_W'(w_row) * ADDR_W'(IMG_W)
                + ADDR_W'(w_ix);
  assign w_addr = w_oob ? '0 : w_lin;

  // Address stage plus blank/oob delay line matching ROM latency.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_addr <= '0;
      r_bl_sr    <= '0;
      r_oob_sr   <= '0;
    end else begin
      r_rom_addr <= w_addr;
      r_bl_sr    <= {r_bl_sr[ROM_LAT-1:0], bus.blank};
      r_oob_sr   <= {r_oob_sr[ROM_LAT-1:0], w_oob};
    end
  end

  assign w_vis = r_bl_sr[ROM_LAT] & ~r_oob_sr[ROM_LAT];

  // Output stage: colour and key flag only for visible in-image pixels.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb   <= 12'd0;
      r_trans <= 1'b0;
    end else begin
      r_rgb   <= w_vis ? bus.pal_rgb : 12'd0;
      r_trans <= w_vis
              && (bus.rom_q == IDX_W'(KEY_IDX));
    end
  end

  assign bus.rom_addr    = r_rom_addr;
  assign bus.red         = r_rgb[11:8];
  assign bus.green       = r_rgb[7:4];
  assign bus.blue        = r_rgb[3:0];
  assign bus.transparent = r_trans;
  assign bus.x_off       = r_x_off;
`ifdef VSCROLL_EN
  assign bus.y_off       = r_y_off;
`endif

endmodule

// File: tb/tb_scroll_bg_mapper.sv
// Directed bench for scroll_bg_mapper (ROM_LAT=1).
// Second instance uses IMG_W=256 for out-of-image cases.
module tb_scroll_bg_mapper;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  scroll_bg_mapper_if #(.ADDR_W(18), .IDX_W(5)) bus();
  scroll_bg_mapper_if #(.ADDR_W(18), .IDX_W(5)) bus2();

  scroll_bg_mapper #(
    .IMG_W(320), .IMG_H(240), .SCALE_SHIFT(1),
    .ADDR_W(18), .IDX_W(5), .ROM_LAT(1),
    .V_ACTIVE(480), .KEY_IDX(0)
  ) dut (
    .vga_clk(clk), .reset_n(rst_n), .bus(bus)
  );

  scroll_bg_mapper #(
    .IMG_W(256), .IMG_H(240), .SCALE_SHIFT(1),
    .ADDR_W(18), .IDX_W(5), .ROM_LAT(1),
    .V_ACTIVE(480), .KEY_IDX(0)
  ) dut2 (
    .vga_clk(clk), .reset_n(rst_n), .bus(bus2)
  );

  function automatic logic [4:0] rom_f(input logic [17:0] a);
    return a[4:0];
  endfunction

  function automatic logic [11:0] pal_f(input logic [4:0] i);
    return {i[3:0], ~i[3:0], 3'b010, i[4]};
  endfunction

  always @(posedge clk) begin
    bus.rom_q  <= rom_f(bus.rom_addr);
    bus2.rom_q <= rom_f(bus2.rom_addr);
  end

  assign bus.pal_rgb  = pal_f(bus.rom_q);
  assign bus2.pal_rgb = pal_f(bus2.rom_q);
  assign bus2.DrawX   = bus.DrawX;
  assign bus2.DrawY   = bus.DrawY;
  assign bus2.blank   = bus.blank;
  assign bus2.mode    = bus.mode;
  assign bus2.speed   = bus.speed;
`ifdef VSCROLL_EN
  assign bus.vspeed   = 4'd0;
  assign bus2.vspeed  = 4'd0;
`endif

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, exp);
    end
  endtask

  function automatic int rgb1();
    return int'({bus.red, bus.green, bus.blue});
  endfunction

  function automatic int rgb2();
    return int'({bus2.red, bus2.green, bus2.blue});
  endfunction

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       b;
    int         a1;
    int         a2;
    logic       o1;
    logic       o2;
  } vec_t;

  localparam int N = 8;
  vec_t v[N];

  task automatic drive(input logic [9:0] x, input logic [9:0] y,
                       input logic b);
    bus.DrawX = x;
    bus.DrawY = y;
    bus.blank = b;
  endtask

  task automatic frame();
    drive(10'd0, 10'd480, 1'b0);
    @(posedge clk); #1;
    drive(10'd0, 10'd481, 1'b0);
  endtask

  int exp_x;
  int idx;
  int er;
  int et;
  logic vis;

  initial begin
    v[0] = '{10'd6,   10'd4,   1'b1, 643,   515, 1'b0, 1'b0};
    v[1] = '{10'd0,   10'd4,   1'b1, 640,   512, 1'b0, 1'b0};
    v[2] = '{10'd0,   10'd4,   1'b0, 640,   512, 1'b0, 1'b0};
    v[3] = '{10'd639, 10'd479, 1'b1, 76799, 0,   1'b0, 1'b1};
    v[4] = '{10'd640, 10'd10,  1'b1, 0,     0,   1'b1, 1'b1};
    v[5] = '{10'd100, 10'd500, 1'b1, 0,     0,   1'b1, 1'b1};
    v[6] = '{10'd1,   10'd1,   1'b1, 0,     0,   1'b0, 1'b0};
    v[7] = '{10'd33,  10'd0,   1'b1, 16,    16,  1'b0, 1'b0};

    drive(10'd0, 10'd0, 1'b0);
    bus.mode  = 2'b00;
    bus.speed = 4'd0;
    #12;
    chk("rst_rgb", rgb1(), 0);
    chk("rst_trans", int'(bus.transparent), 0);
    chk("rst_xoff", int'(bus.x_off), 0);
    chk("rst_addr", int'(bus.rom_addr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int c = 0; c < N + 3; c++) begin
      if (c < N) drive(v[c].x, v[c].y, v[c].b);
      else drive(10'd0, 10'd0, 1'b0);
      @(posedge clk); #1;
      if (c < N) begin
        chk($sformatf("addr[%0d]", c),
            int'(bus.rom_addr), v[c].a1);
        chk($sformatf("addr256[%0d]", c),
            int'(bus2.rom_addr), v[c].a2);
      end
      if (c >= 2 && c - 2 < N) begin
        idx = c - 2;
        vis = v[idx].b && !v[idx].o1;
        er  = vis ? int'(pal_f(rom_f(18'(v[idx].a1)))) : 0;
        et  = (vis && rom_f(18'(v[idx].a1)) == 5'd0) ? 1 : 0;
        chk($sformatf("rgb[%0d]", idx), rgb1(), er);
        chk($sformatf("trans[%0d]", idx),
            int'(bus.transparent), et);
        vis = v[idx].b && !v[idx].o2;
        er  = vis ? int'(pal_f(rom_f(18'(v[idx].a2)))) : 0;
        et  = (vis && rom_f(18'(v[idx].a2)) == 5'd0) ? 1 : 0;
        chk($sformatf("rgb256[%0d]", idx), rgb2(), er);
        chk($sformatf("trans256[%0d]", idx),
            int'(bus2.transparent), et);
      end
    end

    bus.mode  = 2'b01;
    bus.speed = 4'd5;
    exp_x = 0;
    for (int k = 1; k <= 70; k++) begin
      frame();
      exp_x = (exp_x + 5) % 320;
      chk($sformatf("right_f%0d", k), int'(bus.x_off), exp_x);
    end

    bus.mode = 2'b11;
    frame();
    chk("home", int'(bus.x_off), 0);
    bus.mode  = 2'b10;
    bus.speed = 4'd2;
    frame();
    chk("left_wrap318", int'(bus.x_off), 318);

    drive(10'd4, 10'd0, 1'b1);
    @(posedge clk); #1;
    chk("wrap_addr0", int'(bus.rom_addr), 0);
    drive(10'd6, 10'd0, 1'b1);
    @(posedge clk); #1;
    chk("wrap_addr1", int'(bus.rom_addr), 1);

    bus.mode  = 2'b01;
    bus.speed = 4'd3;
    frame();
    chk("right_to1", int'(bus.x_off), 1);
    bus.mode = 2'b10;
    frame();
    chk("left_318", int'(bus.x_off), 318);
    frame();
    chk("left_315", int'(bus.x_off), 315);

    bus.mode = 2'b11;
    drive(10'd5, 10'd100, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    drive(10'd1, 10'd480, 1'b0);
    @(posedge clk); #1;
    drive(10'd0, 10'd479, 1'b0);
    @(posedge clk); #1;
    chk("midframe_mode", int'(bus.x_off), 315);
    bus.mode = 2'b00;
    frame();
    chk("hold", int'(bus.x_off), 315);
    bus.mode  = 2'b01;
    bus.speed = 4'd0;
    frame();
    chk("speed0", int'(bus.x_off), 315);
    bus.mode = 2'b11;
    frame();
    chk("home2", int'(bus.x_off), 0);

    bus.mode  = 2'b01;
    bus.speed = 4'd5;
    frame();
    frame();
    chk("pre_rst_xoff", int'(bus.x_off), 10);
    drive(10'd6, 10'd4, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_addr", int'(bus.rom_addr), 653);
    chk("pre_rst_rgb", rgb1(), int'(pal_f(5'd13)));
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rgb", rgb1(), 0);
    chk("arst_xoff", int'(bus.x_off), 0);
    chk("arst_addr", int'(bus.rom_addr), 0);
    drive(10'd6, 10'd4, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    drive(10'd6, 10'd4, 1'b1);
    @(posedge clk); #1;
    chk("rel_c1_addr", int'(bus.rom_addr), 643);
    chk("rel_c1_rgb", rgb1(), 0);
    @(posedge clk); #1;
    chk("rel_c2_rgb", rgb1(), 0);
    @(posedge clk); #1;
    chk("rel_c3_rgb", rgb1(), int'(pal_f(5'd3)));
    chk("rel_c3_trans", int'(bus.transparent), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
